// File: rtl/sram1rw_ctrl_pkg.sv
// rtl/sram1rw_ctrl_pkg.sv - shared types and macro geometry for the SRAM1RW request controller
package sram1rw_ctrl_pkg;

  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - flop-based ring buffer with valid/ready on both sides and occupancy count
module sram_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign in_ready  = (r_count != CNT_W'(DEPTH)) | out_ready;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram1rw_req_ctrl.sv
// rtl/sram1rw_req_ctrl.sv - request/response controller for the SRAM1RW256x64 single-port macro
module sram1rw_req_ctrl
  import sram1rw_ctrl_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int RSP_DEPTH     = 3,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_init_addr;
  logic              r_inflight;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_in_ready;
  logic [CRD_W-1:0]  w_credit;
  logic              w_fire;

  // Reserve a FIFO slot for every read still in the macro so a push never meets a full FIFO.
  assign w_credit  = CRD_W'(w_fifo_count) + CRD_W'(r_inflight);
  assign req_ready = (r_state == ST_RUN) && (w_credit < CRD_W'(RSP_DEPTH));
  assign w_fire    = req_valid & req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init_addr <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_addr <= r_init_addr + 1'b1;
      end
      r_inflight <= w_fire & ~req_write;
    end
  end

  // Strobes are gated by reset_n so the macro is released the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    sram_csb    = 1'b1;
    sram_web    = 1'b1;
    sram_oeb    = 1'b1;
    sram_a      = req_addr;
    sram_i      = req_wdata;
    if (reset_n) begin
      case (r_state)
        ST_INIT: begin
          if (INIT_ON_RESET != 0) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = r_init_addr;
            sram_i   = '0;
            if (r_init_addr == '1) begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          sram_csb = ~w_fire;
          sram_web = ~(w_fire & req_write);
          sram_oeb = ~(w_fire & ~req_write);
        end
      endcase
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (r_inflight & w_fifo_in_ready),
    .in_ready  (w_fifo_in_ready),
    .in_data   (sram_o),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (rsp_rdata),
    .count     (w_fifo_count)
  );

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// tb/tb_sram1rw_req_ctrl.sv - randomized bench with SRAM macro model and scoreboard for sram1rw_req_ctrl
module tb_sram1rw_req_ctrl;

  localparam int DEPTH = 3;

  logic        clock;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        sram_csb, sram_web, sram_oeb;
  logic [7:0]  sram_a;
  logic [63:0] sram_i, sram_o;

  logic        b_reset_n;
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [7:0]  b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [63:0] b_rsp_rdata;
  logic        b_csb, b_web, b_oeb;
  logic [7:0]  b_a;
  logic [63:0] b_i, b_o;
  logic        b_wrote = 1'b0;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int base;
  logic [63:0] sram_mem [256];
  logic [63:0] b_mem [256];
  logic [63:0] ref_mem [256];
  logic [63:0] exp_q [$];
  logic [63:0] exp_data;

  sram1rw_req_ctrl #(.ADDR_W(8), .DATA_W(64), .RSP_DEPTH(DEPTH), .INIT_ON_RESET(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .sram_csb(sram_csb), .sram_web(sram_web),
    .sram_oeb(sram_oeb), .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
  );

  sram1rw_req_ctrl #(.ADDR_W(8), .DATA_W(64), .RSP_DEPTH(DEPTH), .INIT_ON_RESET(0)) u_dut_noinit (
    .clock(clock), .reset_n(b_reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .sram_csb(b_csb), .sram_web(b_web),
    .sram_oeb(b_oeb), .sram_a(b_a), .sram_i(b_i), .sram_o(b_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro models: CE tied to clock, output holds when not reading.
  initial begin
    for (int k = 0; k < 256; k++) begin
      sram_mem[k] <= {$urandom, $urandom} | 64'h1;
      b_mem[k]    <= 64'h0123_4567_0000_0000 + 64'(k);
    end
  end

  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_a] <= sram_i;
      if (!sram_oeb) sram_o <= sram_mem[sram_a];
    end
  end

  always @(posedge clock) begin
    if (!b_csb) begin
      if (!b_web) begin
        b_mem[b_a] <= b_i;
        b_wrote    <= 1'b1;
      end
      if (!b_oeb) b_o <= b_mem[b_a];
    end
  end

  // Scoreboard: values are stable at the falling edge and apply at the next rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else           exp_q.push_back(ref_mem[req_addr]);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got %h, expected no response", rsp_rdata);
        end else begin
          exp_data = exp_q.pop_front();
          if (rsp_rdata !== exp_data) begin
            errors++;
            $display("FAIL rsp_data: got %h, expected %h", rsp_rdata, exp_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_ref();
    for (int k = 0; k < 256; k++) ref_mem[k] = '0;
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [63:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    #2;
    while (!req_ready && n < 50) begin
      tick();
      #2;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept_timeout: req_ready=%b, expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      tick();
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d rsp_valid=%b, expected 0/0", exp_q.size(), rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    int c0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    #2;
    checks++;
    if ({req_ready, rsp_valid, sram_csb, sram_web, sram_oeb} !== 5'b00111) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00111",
               {req_ready, rsp_valid, sram_csb, sram_web, sram_oeb});
    end
    tick();
    reset_n = 1'b1;
    zero_ref();
    for (int k = 0; k < 256; k++) begin
      #2;
      checks++;
      if (req_ready !== 1'b0 || sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 8'(k) || sram_i !== 64'h0) begin
        errors++;
        $display("FAIL init_cycle %0d: ready=%b csb=%b web=%b a=%h i=%h, expected 0 0 0 %h 0",
                 k, req_ready, sram_csb, sram_web, sram_a, sram_i, 8'(k));
      end
      tick();
    end
    #2;
    checks++;
    if ({req_ready, sram_csb, sram_web, sram_oeb} !== 4'b1111) begin
      errors++;
      $display("FAIL init_done_idle: got %b, expected 1111", {req_ready, sram_csb, sram_web, sram_oeb});
    end
    tick();
    c0 = rsp_cnt;
    do_req(1'b0, 8'h00, '0);
    do_req(1'b0, 8'h7F, '0);
    do_req(1'b0, 8'hFF, '0);
    wait_drain();
    checks++;
    if (rsp_cnt - c0 != 3) begin
      errors++;
      $display("FAIL init_read_count: got %0d, expected 3", rsp_cnt - c0);
    end
  endtask

  task automatic test_raw();
    logic [63:0] v;
    v = 64'hA5A5_0000_DEAD_BEEF;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h12; req_wdata = v;
    #2;
    checks++;
    if ({req_ready, sram_csb, sram_web, sram_oeb} !== 4'b1001) begin
      errors++;
      $display("FAIL raw_write_strobes: got %b, expected 1001", {req_ready, sram_csb, sram_web, sram_oeb});
    end
    tick();
    req_write = 1'b0; req_wdata = {$urandom, $urandom};
    #2;
    checks++;
    if ({req_ready, sram_csb, sram_web, sram_oeb} !== 4'b1010 || sram_a !== 8'h12) begin
      errors++;
      $display("FAIL raw_read_strobes: got %b a=%h, expected 1010 a=12",
               {req_ready, sram_csb, sram_web, sram_oeb}, sram_a);
    end
    tick();
    req_valid = 1'b0;
    #2;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_latency_early: rsp_valid=%b, expected 0", rsp_valid);
    end
    tick();
    #2;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== v) begin
      errors++;
      $display("FAIL raw_response: valid=%b data=%h, expected 1 %h", rsp_valid, rsp_rdata, v);
    end
    tick();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [16];
    logic        exp_v;
    base = int'($urandom_range(32, 200));
    req_valid = 1'b1; req_write = 1'b1;
    for (int k = 0; k < 16; k++) begin
      d[k] = {$urandom, $urandom};
      req_addr = 8'(base + k); req_wdata = d[k];
      #2;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_write_ready %0d: got %b, expected 1", k, req_ready);
      end
      tick();
    end
    req_write = 1'b0;
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin
        req_valid = 1'b1; req_addr = 8'(base + c);
      end else begin
        req_valid = 1'b0;
      end
      #2;
      if (c < 16) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_read_ready %0d: got %b, expected 1", c, req_ready);
        end
      end
      exp_v = (c >= 2 && c <= 17);
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_rsp_valid %0d: got %b, expected %b", c, rsp_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (rsp_rdata !== d[c-2]) begin
          errors++;
          $display("FAIL b2b_order %0d: got %h, expected %h", c, rsp_rdata, d[c-2]);
        end
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int          acc;
    logic [63:0] hold;
    acc = 0;
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_addr = 8'(base + int'($urandom_range(0, 15)));
      #2;
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    #2;
    checks++;
    if (acc != DEPTH || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_accepted: got %0d ready=%b valid=%b, expected %0d 0 1", acc, req_ready, rsp_valid, DEPTH);
    end
    hold = rsp_rdata;
    checks++;
    if (exp_q.size() == 0 || hold !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_head: got %h, expected head of %0d pending", hold, exp_q.size());
    end
    repeat (3) tick();
    #2;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== hold || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h ready=%b, expected 1 %h 0", rsp_valid, rsp_rdata, req_ready, hold);
    end
    rsp_ready = 1'b1;
    wait_drain();
    #2;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_back: got %b, expected 1", req_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    int c0;
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_addr = 8'(base + c);
      #2;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_issue %0d: ready=%b, expected 1", c, req_ready);
      end
      tick();
    end
    #1;
    reset_n = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, sram_csb, req_ready} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset_async: got %b, expected 010", {rsp_valid, sram_csb, req_ready});
    end
    repeat (2) tick();
    reset_n = 1'b1;
    zero_ref();
    rsp_ready = 1'b1;
    n = 0; seen = 0;
    #2;
    while (!req_ready && n < 300) begin
      if (rsp_valid) seen++;
      tick();
      #2;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1 || n != 256 || seen != 0) begin
      errors++;
      $display("FAIL mid_reinit: ready=%b cycles=%0d stale=%0d, expected 1 256 0", req_ready, n, seen);
    end
    tick();
    c0 = rsp_cnt;
    do_req(1'b0, 8'(base), '0);
    wait_drain();
    checks++;
    if (rsp_cnt - c0 != 1) begin
      errors++;
      $display("FAIL mid_post_count: got %0d, expected 1", rsp_cnt - c0);
    end
  endtask

  task automatic test_no_init();
    b_reset_n = 1'b1;
    #2;
    checks++;
    if ({b_req_ready, b_csb, b_web, b_oeb} !== 4'b0111) begin
      errors++;
      $display("FAIL noinit_first: got %b, expected 0111", {b_req_ready, b_csb, b_web, b_oeb});
    end
    tick();
    #2;
    checks++;
    if (b_req_ready !== 1'b1 || b_wrote !== 1'b0) begin
      errors++;
      $display("FAIL noinit_ready: ready=%b wrote=%b, expected 1 0", b_req_ready, b_wrote);
    end
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h05;
    tick();
    b_req_valid = 1'b0;
    tick();
    #2;
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'h0123_4567_0000_0005) begin
      errors++;
      $display("FAIL noinit_read: valid=%b data=%h, expected 1 0123456700000005", b_rsp_valid, b_rsp_rdata);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    b_reset_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_rsp_ready = 1'b1;
    test_reset();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_no_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
